// File: rtl/led_trail_driver.sv
// ============================================================================
// led_trail_driver : PWM-dimmed fading trail, position/direction tracking and
//                    sticky input-error flag for an 8-bit bouncing one-hot.
// Revision 1.0
// ============================================================================
`default_nettype none

module led_trail_driver #(
  parameter int BW      = 4,
  parameter int DECAY   = 4,
  parameter int SWEEP_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [7:0]         pos,
  output logic [7:0]         led,
  output logic [2:0]         idx,
  output logic               dir,
  output logic [SWEEP_W-1:0] sweep_count,
  output logic               err
);

  localparam logic [BW-1:0] MAX    = '1;
  localparam logic [BW-1:0] DEC_BW = BW'(DECAY);

  logic [BW-1:0]      bright_q [8];
  logic [BW-1:0]      bright_d [8];
  logic [7:0]         prev_pos_q, prev_pos_d;
  logic               have_prev_q, have_prev_d;
  logic [BW-1:0]      pwm_cnt_q, pwm_cnt_d;
  logic [7:0]         led_q, led_d;
  logic [2:0]         idx_q, idx_d;
  logic               dir_q, dir_d;
  logic [SWEEP_W-1:0] sweep_count_q, sweep_count_d;
  logic               err_q, err_d;

  logic       onehot;
  logic [2:0] new_idx;
  logic       adjacent;
  logic       step_dir;

  always_comb begin
    onehot  = (pos != 8'd0) && ((pos & (pos - 8'd1)) == 8'd0);
    new_idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (pos[i]) new_idx = 3'(i);
    end
    step_dir = (new_idx < idx_q);
    adjacent = ({1'b0, new_idx} == {1'b0, idx_q} + 4'd1) ||
               ({1'b0, idx_q} == {1'b0, new_idx} + 4'd1);
  end

  always_comb begin
    bright_d      = bright_q;
    prev_pos_d    = prev_pos_q;
    have_prev_d   = have_prev_q;
    idx_d         = idx_q;
    dir_d         = dir_q;
    sweep_count_d = sweep_count_q;
    err_d         = err_q;
    pwm_cnt_d     = (pwm_cnt_q == MAX - 1'b1) ? '0 : pwm_cnt_q + 1'b1;
    for (int i = 0; i < 8; i++) begin
      led_d[i] = (bright_q[i] > pwm_cnt_q);
    end

    if (!onehot) begin
      err_d = 1'b1;
    end else if (pos != prev_pos_q) begin
      prev_pos_d  = pos;
      have_prev_d = 1'b1;
      idx_d       = new_idx;
      if (have_prev_q) begin
        // Step and Jump share the decay; only a Step may reverse direction.
        for (int i = 0; i < 8; i++) begin
          bright_d[i] = (int'(bright_q[i]) > DECAY) ? bright_q[i] - DEC_BW : '0;
        end
        if (adjacent) begin
          if (step_dir != dir_q) begin
            dir_d         = step_dir;
            sweep_count_d = sweep_count_q + SWEEP_W'(1);
          end
        end else begin
          err_d = 1'b1;
        end
      end
      bright_d[new_idx] = MAX;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) bright_q[i] <= '0;
      prev_pos_q    <= '0;
      have_prev_q   <= 1'b0;
      pwm_cnt_q     <= '0;
      led_q         <= '0;
      idx_q         <= '0;
      dir_q         <= 1'b0;
      sweep_count_q <= '0;
      err_q         <= 1'b0;
    end else begin
      bright_q      <= bright_d;
      prev_pos_q    <= prev_pos_d;
      have_prev_q   <= have_prev_d;
      pwm_cnt_q     <= pwm_cnt_d;
      led_q         <= led_d;
      idx_q         <= idx_d;
      dir_q         <= dir_d;
      sweep_count_q <= sweep_count_d;
      err_q         <= err_d;
    end
  end

  assign led         = led_q;
  assign idx         = idx_q;
  assign dir         = dir_q;
  assign sweep_count = sweep_count_q;
  assign err         = err_q;

endmodule

`default_nettype wire

// File: tb/tb_led_trail_driver.sv
// ============================================================================
// tb_led_trail_driver : table-driven directed bench; brightness is observed
//                       as LED on-count over one full 15-cycle PWM period.
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_led_trail_driver;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  pos;
  logic [7:0]  led;
  logic [2:0]  idx;
  logic        dir;
  logic [15:0] sweep_count;
  logic        err;

  int checks = 0;
  int errors = 0;

  led_trail_driver #(.BW(4), .DECAY(4), .SWEEP_W(16)) dut (
    .clk(clk), .reset(reset), .pos(pos), .led(led), .idx(idx),
    .dir(dir), .sweep_count(sweep_count), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        rst;
    logic [7:0]  pos;
    logic [2:0]  idx;
    logic        dir;
    logic [15:0] sw;
    logic        err;
    logic        chk;
    logic [31:0] br;   // expected brightness, nibble i = LED i
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t row(input logic r, input logic [7:0] p, input logic [2:0] i,
                               input logic d, input logic [15:0] s, input logic e,
                               input logic c, input logic [31:0] b);
    vec_t v;
    v.rst = r; v.pos = p; v.idx = i; v.dir = d; v.sw = s; v.err = e; v.chk = c; v.br = b;
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Count LED-on cycles across one full PWM period while pos is held.
  task automatic duty(input int n, input logic [31:0] br);
    int cnt[8];
    logic [31:0] b;
    b = br;
    for (int j = 0; j < 8; j++) cnt[j] = 0;
    for (int c = 0; c < 15; c++) begin
      @(posedge clk); #1;
      for (int j = 0; j < 8; j++) cnt[j] += int'(led[j]);
    end
    for (int j = 0; j < 8; j++)
      check($sformatf("row%0d duty led[%0d]", n, j), cnt[j], int'(b[4*j +: 4]));
  endtask

  initial begin
    reset = 1'b1;
    pos   = 8'h00;

    vecs.push_back(row(1, 8'h01, 0, 0, 0, 0, 0, 32'h0));
    vecs.push_back(row(1, 8'h01, 0, 0, 0, 0, 0, 32'h0));
    vecs.push_back(row(0, 8'h01, 0, 0, 0, 0, 1, 32'h0000000F));
    vecs.push_back(row(0, 8'h02, 1, 0, 0, 0, 0, 32'h0));
    vecs.push_back(row(0, 8'h04, 2, 0, 0, 0, 0, 32'h0));
    vecs.push_back(row(0, 8'h08, 3, 0, 0, 0, 1, 32'h0000FB73));
    vecs.push_back(row(0, 8'h10, 4, 0, 0, 0, 0, 32'h0));
    vecs.push_back(row(0, 8'h20, 5, 0, 0, 0, 1, 32'h00FB7300));
    vecs.push_back(row(0, 8'h40, 6, 0, 0, 0, 0, 32'h0));
    vecs.push_back(row(0, 8'h80, 7, 0, 0, 0, 0, 32'h0));
    vecs.push_back(row(0, 8'h40, 6, 1, 1, 0, 1, 32'hBF300000));
    vecs.push_back(row(0, 8'h20, 5, 1, 1, 0, 0, 32'h0));
    vecs.push_back(row(0, 8'h10, 4, 1, 1, 0, 0, 32'h0));
    vecs.push_back(row(0, 8'h08, 3, 1, 1, 0, 0, 32'h0));
    vecs.push_back(row(0, 8'h04, 2, 1, 1, 0, 0, 32'h0));
    vecs.push_back(row(0, 8'h02, 1, 1, 1, 0, 0, 32'h0));
    vecs.push_back(row(0, 8'h01, 0, 1, 1, 0, 0, 32'h0));
    vecs.push_back(row(0, 8'h02, 1, 0, 2, 0, 0, 32'h0));
    vecs.push_back(row(0, 8'h04, 2, 0, 2, 0, 1, 32'h00000FB7));
    vecs.push_back(row(0, 8'h00, 2, 0, 2, 1, 0, 32'h0));
    vecs.push_back(row(0, 8'h06, 2, 0, 2, 1, 1, 32'h00000FB7));
    vecs.push_back(row(0, 8'h08, 3, 0, 2, 1, 1, 32'h0000FB73));
    vecs.push_back(row(0, 8'h04, 2, 1, 3, 1, 0, 32'h0));
    vecs.push_back(row(0, 8'h02, 1, 1, 3, 1, 0, 32'h0));
    vecs.push_back(row(0, 8'h20, 5, 1, 3, 1, 1, 32'h00F037B0));
    vecs.push_back(row(1, 8'h20, 0, 0, 0, 0, 0, 32'h0));
    vecs.push_back(row(0, 8'h10, 4, 0, 0, 0, 1, 32'h000F0000));
    vecs.push_back(row(0, 8'h02, 1, 0, 0, 1, 0, 32'h0));
    vecs.push_back(row(0, 8'h40, 6, 0, 0, 1, 1, 32'h0F0700B0));
    vecs.push_back(row(1, 8'h03, 0, 0, 0, 0, 0, 32'h0));
    vecs.push_back(row(0, 8'h01, 0, 0, 0, 0, 1, 32'h0000000F));

    for (int n = 0; n < vecs.size(); n++) begin
      reset = vecs[n].rst;
      pos   = vecs[n].pos;
      @(posedge clk); #1;
      check($sformatf("row%0d idx", n), int'(idx), int'(vecs[n].idx));
      check($sformatf("row%0d dir", n), int'(dir), int'(vecs[n].dir));
      check($sformatf("row%0d sweep_count", n), int'(sweep_count), int'(vecs[n].sw));
      check($sformatf("row%0d err", n), int'(err), int'(vecs[n].err));
      if (vecs[n].rst) check($sformatf("row%0d led", n), int'(led), 0);
      if (vecs[n].chk) duty(n, vecs[n].br);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/led_trail_driver.md
# led_trail_driver

Downstream consumer of the 8-bit bouncing one-hot shift counter. Samples the counter's one-hot position every clock and produces three things:
- a PWM-dimmed "trail" LED output, where the lit LED is full brightness and previously lit LEDs fade step by step;
- the encoded position and sweep direction, plus a completed-sweep count;
- a sticky error flag for illegal input patterns.

## Interface

Parameters:
- BW, 4: brightness / PWM counter width; MAX = 2^BW − 1.
- DECAY, 4: brightness subtracted from every unlit LED per position step (saturating at 0).
- SWEEP_W, 16: width of the sweep counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- pos  in  8  one-hot position from the shift counter.
- led  out  8  PWM-driven LED outputs, registered.
- idx  out  3  binary index of last accepted position, registered.
- dir  out  1  0 = moving toward bit 7, 1 = moving toward bit 0.
- sweep_count  out  SWEEP_W  number of direction reversals, wraps modulo 2^SWEEP_W.
- err  out  1  sticky illegal-input flag.

## Operation

Internal state:
- bright[0..7] (BW bits each);
- prev_pos (8 bits);
- have_prev (1 bit);
- pwm_cnt (BW bits).

Input classification, evaluated every cycle on the current pos:
- **Illegal**: pos is zero or has more than one bit set.
  - err ← 1.
  - No other state changes; the sample is ignored.
- **Unchanged**: pos is one-hot and equals prev_pos. No update.
- **First**: pos is one-hot and have_prev = 0.
  - Accept the sample.
  - bright[new] ← MAX; all other bright unchanged.
  - idx ← encode(pos); have_prev ← 1.
  - dir and sweep_count unchanged.
- **Step**: pos is one-hot, differs from prev_pos, and is adjacent (encode differs by exactly 1).
  - bright[new] ← MAX.
  - Every other bright[i] ← max(bright[i] − DECAY, 0).
  - idx ← encode(pos).
  - New direction d = 0 if index increased, 1 if it decreased.
  - If d ≠ dir: dir ← d and sweep_count ← sweep_count + 1 (wrapping).
- **Jump**: pos is one-hot, differs from prev_pos, and is not adjacent.
  - err ← 1.
  - Resynchronise: apply the same bright and idx updates as Step.
  - dir and sweep_count unchanged.

On every accepted sample (First, Step, Jump): prev_pos ← pos.

PWM:
- pwm_cnt counts 0 → MAX−1, then wraps to 0; period MAX cycles. It runs continuously from reset.
- led[i] ← (bright[i] > pwm_cnt), registered.
- Consequences: bright = MAX gives always on; bright = 0 gives always off; duty = bright/MAX.

err:
- Clears only on reset.
- Once set, it does not stop normal processing of later legal samples.

## Timing

- Reset values: led = 0, idx = 0, dir = 0, sweep_count = 0, err = 0. Internally bright[*] = 0, prev_pos = 0, have_prev = 0, pwm_cnt = 0.
- Reset is synchronous and dominates all other activity, including mid-sweep. The first legal sample after reset is classified First.
- pos is sampled at rising edge N.
  - idx, dir, sweep_count, err and bright are updated at edge N (one clock of latency after pos becomes valid).
  - led reflects the new bright at edge N+1.
- pos is expected to change at most once per clock. A change every clock is legal: decay then occurs every clock.
- Endpoint reversal:
  - At 0x80 arriving while dir = 0, no change yet: the step into bit 7 is still upward.
  - The following 0x40 sets dir = 1 and increments sweep_count in the same edge.
  - The 0x01 end behaves symmetrically.
- Saturation: DECAY ≥ bright sets the LED to 0; it never wraps negative.
- An illegal sample and reset in the same cycle: reset wins, so err = 0.

## Test plan

1. **Reset then first sample.**
   - Stimulus: reset for 2 cycles, then pos = 0x01 held.
   - Required: idx = 0, dir = 0, sweep_count = 0, err = 0. bright[0] = 15; led[0] high every cycle from 1 cycle after acceptance; led[7:1] = 0.
2. **Trail decay with DECAY = 4.**
   - Stimulus: pos = 0x01, 0x02, 0x04, 0x08, one per cycle.
   - Required: bright[3:0] = 15, 11, 7, 3. Over a 15-cycle window, led[2] is high for exactly 11 cycles and led[0] for exactly 3.
   - Continue to 0x10 and 0x20: bright[0] then = 0.
3. **Full bounce.**
   - Stimulus: drive the counter sequence 0x01 → 0x80 → 0x01 → 0x02.
   - Required: dir goes 0 → 1 on the 0x40 after 0x80, and 1 → 0 on the 0x02 after 0x01. sweep_count = 2, err = 0.
4. **Illegal inputs.**
   - Stimulus: after 0x04 is accepted, drive 0x00, then 0x06, then 0x08.
   - Required: err = 1 after 0x00. idx stays 2 and bright stays unchanged across both illegal samples. 0x08 is accepted as a Step: idx = 3, and err stays 1.
5. **Jump resync.**
   - Stimulus: 0x02 then 0x40.
   - Required: err = 1, idx = 6, bright[6] = 15, bright[1] = 11, dir and sweep_count unchanged.
6. **Reset mid-sweep.**
   - Stimulus: assert reset while pos = 0x20 with err = 1 and sweep_count = 3; release with pos = 0x10.
   - Required: all outputs return to reset values. 0x10 is treated as First: idx = 4, dir = 0, no sweep increment, err = 0.
